// File: rtl/processing_hw_prod_accum.sv
// processing_hw_prod_accum: accumulates product groups and emits rounded, shifted, saturated results through a 2-entry buffer
module processing_hw_prod_accum #(
  parameter int P_W = 25,
  parameter int ACC_LEN = 16,
  parameter int SHIFT = 10,
  parameter int OUT_W = 16,
  parameter int ACC_W = P_W + $clog2(ACC_LEN),
  parameter int CNT_W = $clog2(ACC_LEN) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p_valid,
  input  logic [P_W-1:0]   p_data,
  input  logic             p_last,
  output logic             ce,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);
  typedef enum logic {S_IDLE, S_ACC} state_t;
  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             sat;
  } res_t;
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
  localparam logic [ACC_W:0] MAX = {{(ACC_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};
  state_t state, state_n;
  logic [ACC_W-1:0] acc, acc_n, sum;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [ACC_W:0] r;
  logic beat, close, pop;
  logic [1:0] fcnt;
  res_t e0, e1, res;
  assign ce = fcnt != 2'd2;
  assign beat = ce & p_valid;
  assign sum = (state == S_ACC ? acc : '0) + ACC_W'(p_data);
  assign cnt_inc = (state == S_ACC ? cnt : '0) + 1'b1;
  assign close = beat & (p_last | cnt_inc == CNT_W'(ACC_LEN));
  assign r = ({1'b0, sum} + HALF) >> SHIFT;
  assign res = '{data: r > MAX ? {OUT_W{1'b1}} : r[OUT_W-1:0], count: cnt_inc, sat: r > MAX};
  assign pop = out_valid & out_ready;
  assign out_valid = fcnt != 2'd0;
  assign out_data = e0.data;
  assign out_count = e0.count;
  assign out_sat = e0.sat;
  always_comb begin
    state_n = beat ? (close ? S_IDLE : S_ACC) : state;
    acc_n = beat ? (close ? '0 : sum) : acc;
    cnt_n = beat ? (close ? '0 : cnt_inc) : cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      acc <= '0;
      cnt <= '0;
      fcnt <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      fcnt <= fcnt + 2'(close) - 2'(pop);
      e0 <= (close & (fcnt == 2'd0 | (fcnt == 2'd1 & pop))) ? res : (pop & fcnt == 2'd2) ? e1 : e0;
      e1 <= (close & fcnt == 2'd1 & ~pop) ? res : e1;
    end
  end
endmodule

// File: tb/tb_processing_hw_prod_accum.sv
// tb_processing_hw_prod_accum: table vectors, backpressure/reset sequences and random traffic against a queue-based model
module tb_processing_hw_prod_accum;
  localparam int P_W = 25, ACC_LEN = 16, SHIFT = 10, OUT_W = 16, CNT_W = 5;
  localparam longint OMAX = (64'd1 << OUT_W) - 1;
  logic clk = 0, reset = 0, p_valid = 0, p_last = 0, out_ready = 1;
  logic [P_W-1:0] p_data = '0;
  logic ce, out_valid, out_sat;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  typedef struct {longint data; longint count; longint sat;} res_t;
  typedef struct {int n; int base; int inc; bit last; longint e_data; longint e_count; longint e_sat;} vec_t;
  res_t q[$];
  res_t log_q[$];
  longint msum;
  int mcnt, checks = 0, errors = 0;
  bit acc_flag;
  vec_t tbl[7];
  processing_hw_prod_accum dut (
    .clk(clk), .reset(reset), .p_valid(p_valid), .p_data(p_data), .p_last(p_last),
    .ce(ce), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic res_t result(input longint s, input int n);
    res_t x;
    longint rr = (s + (64'd1 << (SHIFT - 1))) >> SHIFT;
    x.data = rr > OMAX ? OMAX : rr;
    x.sat = rr > OMAX ? 1 : 0;
    x.count = n;
    return x;
  endfunction
  task automatic step();
    bit m_ce;
    res_t d;
    @(negedge clk);
    m_ce = q.size() != 2;
    chk("ce", ce, m_ce);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_count", out_count, q[0].count);
      chk("out_sat", out_sat, q[0].sat);
    end
    acc_flag = m_ce && p_valid;
    if (out_ready && q.size() != 0) begin
      d.data = out_data;
      d.count = out_count;
      d.sat = out_sat;
      log_q.push_back(d);
      void'(q.pop_front());
    end
    if (acc_flag) begin
      msum += p_data;
      mcnt++;
      if (p_last || mcnt == ACC_LEN) begin
        q.push_back(result(msum, mcnt));
        msum = 0;
        mcnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send_beat(input longint d, input bit l);
    int k = 0;
    p_valid = 1;
    p_data = P_W'(d);
    p_last = l;
    do begin
      step();
      k++;
    end while (!acc_flag && k < 50);
    if (!acc_flag) chk("beat_timeout", 0, 1);
    p_valid = 0;
    p_last = 0;
  endtask
  task automatic do_reset();
    p_valid = 0;
    reset = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_ce", ce, 1);
      @(posedge clk);
      #1;
    end
    reset = 0;
    q.delete();
    msum = 0;
    mcnt = 0;
  endtask
  initial begin
    tbl[0] = '{3, 1000, 1000, 1, 6, 3, 0};
    tbl[1] = '{1, 1536, 0, 1, 2, 1, 0};
    tbl[2] = '{1, 1535, 0, 1, 1, 1, 0};
    tbl[3] = '{16, 1024, 0, 0, 16, 16, 0};
    tbl[4] = '{2, 1024, 0, 1, 2, 2, 0};
    tbl[5] = '{16, 33542145, 0, 0, 65535, 16, 1};
    tbl[6] = '{16, 1024, 0, 1, 16, 16, 0};
    do_reset();
    chk("reset_data", out_data, 0);
    chk("reset_count", out_count, 0);
    chk("reset_sat", out_sat, 0);
    for (int t = 0; t < 7; t++) begin
      log_q.delete();
      for (int i = 0; i < tbl[t].n; i++)
        send_beat(tbl[t].base + i * tbl[t].inc, tbl[t].last && i == tbl[t].n - 1);
      repeat (3) step();
      chk($sformatf("tbl%0d_n", t), log_q.size(), 1);
      if (log_q.size() != 0) begin
        chk($sformatf("tbl%0d_data", t), log_q[0].data, tbl[t].e_data);
        chk($sformatf("tbl%0d_count", t), log_q[0].count, tbl[t].e_count);
        chk($sformatf("tbl%0d_sat", t), log_q[0].sat, tbl[t].e_sat);
      end
    end
    log_q.delete();
    out_ready = 0;
    send_beat(1024, 1);
    send_beat(2048, 1);
    chk("bp_ce_low", ce, 0);
    chk("bp_head", out_data, 1);
    p_valid = 1;
    p_data = 3072;
    p_last = 1;
    repeat (3) step();
    out_ready = 1;
    step();
    chk("bp_ce_back", ce, 1);
    for (int k = 0; k < 10 && !acc_flag; k++) step();
    p_valid = 0;
    p_last = 0;
    repeat (4) step();
    chk("bp_n", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) chk($sformatf("bp_out%0d", i), log_q[i].data, i + 1);
    for (int i = 0; i < 5; i++) send_beat(500 + i, 0);
    do_reset();
    log_q.delete();
    send_beat(1024, 0);
    send_beat(1024, 1);
    repeat (3) step();
    chk("rst_n", log_q.size(), 1);
    if (log_q.size() != 0) begin
      chk("rst_data", log_q[0].data, 2);
      chk("rst_count", log_q[0].count, 2);
    end
    for (int c = 0; c < 600; c++) begin
      if (!p_valid && $urandom_range(9) < 7) begin
        p_valid = 1;
        p_data = $urandom_range(1) ? P_W'($urandom_range(0, 4095)) : P_W'($urandom_range(0, 33542145));
        p_last = $urandom_range(4) == 0;
      end
      out_ready = $urandom_range(9) < 6;
      step();
      if (acc_flag) begin
        p_valid = 0;
        p_last = 0;
      end
    end
    p_valid = 0;
    out_ready = 1;
    repeat (5) step();
    chk("drain_empty", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
